// File: rtl/milestone_sequencer.sv
// -----------------------------------------------------------------------------
// milestone_sequencer
//
// Runs the decoder milestones in order over the single external SRAM port:
// UART loader, then IDCT (M2), then colour-space conversion (M1). Each client
// gets a one-cycle start pulse, the sequencer waits for that client's one-cycle
// done pulse, and only the active client is routed to the SRAM port. Idle gap
// states between stages let in-flight writes drain. A per-stage cycle counter
// enforces a timeout on M2/M1 and records how long the last finished stage ran.
//
// Client handshake: x_enable is a single-cycle request issued in X_START.
// x_done is a single-cycle completion pulse that is only accepted while the
// sequencer is in X_RUN; done pulses from a client that does not own the port,
// or that arrive during X_START, are dropped. abort outranks every other input.
//
// Ports:
//   Clock, Resetn                  clock, asynchronous active-low reset
//   start, skip_m2, abort          sequence control (start/skip sampled in IDLE)
//   ld_/m2_/m1_enable              one-cycle start pulses to the clients
//   ld_/m2_/m1_done                one-cycle completion pulses from the clients
//   ld_/m2_/m1_address, _write_data, _we_n   client SRAM requests
//   SRAM_address, SRAM_write_data, SRAM_we_n muxed SRAM port
//   busy, stage, seq_done, error   status
//   last_cycles                    counter value at the last accepted done
//   dbg_state                      raw FSM state for checkers
// -----------------------------------------------------------------------------
module milestone_sequencer #(
  parameter int               CNT_W          = 24,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 24'hFF_FFFF,
  parameter int               GAP_CYCLES     = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              start,
  input  logic              skip_m2,
  input  logic              abort,
  output logic              ld_enable,
  output logic              m2_enable,
  output logic              m1_enable,
  input  logic              ld_done,
  input  logic              m2_done,
  input  logic              m1_done,
  input  logic [17:0]       ld_address,
  input  logic [17:0]       m2_address,
  input  logic [17:0]       m1_address,
  input  logic [15:0]       ld_write_data,
  input  logic [15:0]       m2_write_data,
  input  logic [15:0]       m1_write_data,
  input  logic              ld_we_n,
  input  logic              m2_we_n,
  input  logic              m1_we_n,
  output logic [17:0]       SRAM_address,
  output logic [15:0]       SRAM_write_data,
  output logic              SRAM_we_n,
  output logic              busy,
  output logic [2:0]        stage,
  output logic              seq_done,
  output logic              error,
  output logic [CNT_W-1:0]  last_cycles,
  output logic [3:0]        dbg_state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LD_START = 4'd1;
  localparam logic [3:0] S_LD_RUN   = 4'd2;
  localparam logic [3:0] S_GAP_A    = 4'd3;
  localparam logic [3:0] S_M2_START = 4'd4;
  localparam logic [3:0] S_M2_RUN   = 4'd5;
  localparam logic [3:0] S_GAP_B    = 4'd6;
  localparam logic [3:0] S_M1_START = 4'd7;
  localparam logic [3:0] S_M1_RUN   = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;
  localparam logic [3:0] S_ERROR    = 4'd10;

  // Gap counter runs 0 .. GAP_CYCLES-1, so it needs clog2(GAP_CYCLES) bits
  // (at least one).
  localparam int            GAP_W    = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             skip_q;

  logic in_start;
  logic in_run;
  logic in_gap;
  logic gap_end;
  logic enter_start;
  logic timeout_hit;
  logic accept_done;

  assign in_start = (state == S_LD_START) || (state == S_M2_START) ||
                    (state == S_M1_START);
  assign in_run   = (state == S_LD_RUN) || (state == S_M2_RUN) ||
                    (state == S_M1_RUN);
  assign in_gap   = (state == S_GAP_A) || (state == S_GAP_B);
  assign gap_end  = in_gap && (gap_cnt == GAP_LAST);

  // The counter reads 0 during a START cycle and k in the k-th RUN cycle.
  assign enter_start = (state_next == S_LD_START) ||
                       (state_next == S_M2_START) ||
                       (state_next == S_M1_START);
  assign timeout_hit = (cnt == TIMEOUT_CYCLES);

  // A done counts only from the owning client in its RUN state, and abort
  // cancels it.
  assign accept_done = !abort &&
                       (((state == S_LD_RUN) && ld_done) ||
                        ((state == S_M2_RUN) && m2_done) ||
                        ((state == S_M1_RUN) && m1_done));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start) state_next = S_LD_START;
        S_LD_START: state_next = S_LD_RUN;
        // The loader is paced by the UART, so LD_RUN has no timeout.
        S_LD_RUN:   if (ld_done) state_next = S_GAP_A;
        S_GAP_A:    if (gap_end) state_next = skip_q ? S_M1_START : S_M2_START;
        S_M2_START: state_next = S_M2_RUN;
        // done is checked before the timeout so a done on the last
        // allowed cycle still wins.
        S_M2_RUN: begin
          if (m2_done)          state_next = S_GAP_B;
          else if (timeout_hit) state_next = S_ERROR;
        end
        S_GAP_B:    if (gap_end) state_next = S_M1_START;
        S_M1_START: state_next = S_M1_RUN;
        S_M1_RUN: begin
          if (m1_done)          state_next = S_DONE;
          else if (timeout_hit) state_next = S_ERROR;
        end
        S_DONE:     state_next = S_IDLE;
        S_ERROR:    state_next = S_ERROR;
        default:    state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and captured values
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (enter_start) begin
      cnt <= '0;
    end else if ((in_start || in_run) && (cnt != CNT_MAX)) begin
      // Saturates at all-ones instead of wrapping.
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      gap_cnt <= '0;
    end else if (in_gap && !gap_end) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end else begin
      gap_cnt <= '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      skip_q <= 1'b0;
    end else if ((state == S_IDLE) && start && !abort) begin
      skip_q <= skip_m2;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_cycles <= '0;
    end else if (accept_done) begin
      last_cycles <= cnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all decoded from the registered state
  // ---------------------------------------------------------------------------
  assign ld_enable = (state == S_LD_START);
  assign m2_enable = (state == S_M2_START);
  assign m1_enable = (state == S_M1_START);
  assign busy      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  assign seq_done  = (state == S_DONE);
  assign error     = (state == S_ERROR);
  assign dbg_state = state;

  always_comb begin
    stage = 3'd0;
    case (state)
      S_LD_START, S_LD_RUN: stage = 3'd1;
      S_M2_START, S_M2_RUN: stage = 3'd2;
      S_M1_START, S_M1_RUN: stage = 3'd3;
      S_GAP_A, S_GAP_B:     stage = 3'd4;
      S_DONE:               stage = 3'd5;
      S_ERROR:              stage = 3'd6;
      default:              stage = 3'd0;
    endcase
  end

  // SRAM mux: purely combinational so the owning client sees no extra latency.
  // Non-owning states park the port at address 0 with writes disabled.
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (state)
      S_LD_START, S_LD_RUN: begin
        SRAM_address    = ld_address;
        SRAM_write_data = ld_write_data;
        SRAM_we_n       = ld_we_n;
      end
      S_M2_START, S_M2_RUN: begin
        SRAM_address    = m2_address;
        SRAM_write_data = m2_write_data;
        SRAM_we_n       = m2_we_n;
      end
      S_M1_START, S_M1_RUN: begin
        SRAM_address    = m1_address;
        SRAM_write_data = m1_write_data;
        SRAM_we_n       = m1_we_n;
      end
      default: begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_milestone_sequencer.sv
// -----------------------------------------------------------------------------
// tb_milestone_sequencer
//
// Self-checking bench for milestone_sequencer (GAP_CYCLES=4, TIMEOUT=100).
// Expected per-cycle behaviour comes from a timeline model: each scenario is
// turned into a list of stage segments (start cycle + run cycles, gaps, done,
// error) from which the expected status word, SRAM owner and done drive are
// taken. Stray done/start pulses and random client traffic are mixed in.
// -----------------------------------------------------------------------------
module tb_milestone_sequencer;

  localparam int CNT_W = 24;
  localparam int TMO   = 100;
  localparam int GAP   = 4;
  localparam int W     = 9;   // {stage[2:0], busy, ld_en, m2_en, m1_en, seq_done, error}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  logic              start, skip_m2, abort;
  logic              ld_enable, m2_enable, m1_enable;
  logic              ld_done, m2_done, m1_done;
  logic [17:0]       ld_address, m2_address, m1_address;
  logic [15:0]       ld_write_data, m2_write_data, m1_write_data;
  logic              ld_we_n, m2_we_n, m1_we_n;
  logic [17:0]       SRAM_address;
  logic [15:0]       SRAM_write_data;
  logic              SRAM_we_n;
  logic              busy;
  logic [2:0]        stage;
  logic              seq_done, error;
  logic [CNT_W-1:0]  last_cycles;
  logic [3:0]        dbg_state;

  milestone_sequencer #(
    .CNT_W(CNT_W), .TIMEOUT_CYCLES(24'd100), .GAP_CYCLES(GAP)
  ) dut (
    .Clock(Clock), .Resetn(Resetn),
    .start(start), .skip_m2(skip_m2), .abort(abort),
    .ld_enable(ld_enable), .m2_enable(m2_enable), .m1_enable(m1_enable),
    .ld_done(ld_done), .m2_done(m2_done), .m1_done(m1_done),
    .ld_address(ld_address), .m2_address(m2_address), .m1_address(m1_address),
    .ld_write_data(ld_write_data), .m2_write_data(m2_write_data),
    .m1_write_data(m1_write_data),
    .ld_we_n(ld_we_n), .m2_we_n(m2_we_n), .m1_we_n(m1_we_n),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n),
    .busy(busy), .stage(stage), .seq_done(seq_done), .error(error),
    .last_cycles(last_cycles), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int model_last = 0;
  int ab_idx;
  bit force_m1 = 1'b0;

  logic [W-1:0] exp_q[$];   // expected status word per cycle
  logic [2:0]   drv_q[$];   // owner done pulse to drive per cycle {ld,m2,m1}
  int           acc_q[$];   // counter value of an accepted done, or -1

  typedef struct {
    bit skip;
    int d_ld;
    int d_m2;
    int d_m1;     // 0 = client never finishes (timeout)
    int exp_ev;   // cycle (LD_START = 0) where seq_done or error first shows
    int exp_last;
    bit exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Timeline model
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] own_mask(input int st);
    return (st == 1) ? 3'b100 : (st == 2) ? 3'b010 : (st == 3) ? 3'b001 : 3'b000;
  endfunction

  function automatic logic [W-1:0] mk(input int st, input bit first);
    logic [2:0] en;
    en = first ? own_mask(st) : 3'b000;
    return {3'(st), (st >= 1 && st <= 4), en, (st == 5), (st == 6)};
  endfunction

  task automatic push_one(input int st);
    exp_q.push_back(mk(st, 1'b0));
    drv_q.push_back(3'b000);
    acc_q.push_back(-1);
  endtask

  // One client stage: a start cycle (counter 0) then len run cycles; with a
  // done, the client pulses on the run cycle whose counter equals len.
  task automatic add_seg(input int st, input int len, input bit has_done);
    exp_q.push_back(mk(st, 1'b1));
    drv_q.push_back(3'b000);
    acc_q.push_back(-1);
    for (int k = 1; k <= len; k++) begin
      exp_q.push_back(mk(st, 1'b0));
      if (has_done && k == len) begin
        drv_q.push_back(own_mask(st));
        acc_q.push_back(k);
      end else begin
        drv_q.push_back(3'b000);
        acc_q.push_back(-1);
      end
    end
  endtask

  task automatic build(input bit skip, input int d_ld, input int d_m2,
                       input int d_m1, input int ab);
    bit dead;
    exp_q.delete(); drv_q.delete(); acc_q.delete();
    dead = 1'b0;
    push_one(0);                       // IDLE cycle carrying the start pulse
    add_seg(1, d_ld, 1'b1);
    repeat (GAP) push_one(4);
    if (!skip) begin
      if (d_m2 > 0) begin
        add_seg(2, d_m2, 1'b1);
        repeat (GAP) push_one(4);
      end else begin
        add_seg(2, TMO, 1'b0);
        repeat (3) push_one(6);
        dead = 1'b1;
      end
    end
    if (!dead) begin
      if (d_m1 > 0) begin
        add_seg(3, d_m1, 1'b1);
        push_one(5);
      end else begin
        add_seg(3, TMO, 1'b0);
        repeat (3) push_one(6);
        dead = 1'b1;
      end
    end
    ab_idx = ab;
    if (ab_idx < 0 && dead) ab_idx = exp_q.size() - 1;   // leave ERROR via abort
    if (ab_idx >= 0 && ab_idx < exp_q.size()) begin
      while (exp_q.size() > ab_idx + 1) begin
        void'(exp_q.pop_back());
        void'(drv_q.pop_back());
        void'(acc_q.pop_back());
      end
      acc_q[ab_idx] = -1;              // abort beats a same-cycle done
    end else begin
      ab_idx = -1;
    end
    push_one(0);
    push_one(0);
  endtask

  // ---------------------------------------------------------------------------
  // Driver + per-cycle checking
  // ---------------------------------------------------------------------------
  task automatic run(input bit skip, input int d_ld, input int d_m2, input int d_m1,
                     input int ab, output int ev, output bit ev_err);
    build(skip, d_ld, d_m2, d_m1, ab);
    ev = -1;
    ev_err = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      logic [W-1:0] e;
      logic [2:0]   stray;
      logic [17:0]  ea;
      logic [15:0]  ed;
      logic         ew;
      int           st;
      @(posedge Clock); #1;
      e  = exp_q[c];
      st = int'(e[8:6]);
      stray = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) stray = 3'b000;
      // The owner may pulse done only in its start cycle, where it is ignored.
      if (e[4:2] == 3'b000) stray = stray & ~own_mask(st);
      {ld_done, m2_done, m1_done} = drv_q[c] | stray;
      start   = (c == 0) || (st != 0 && $urandom_range(0, 7) == 0);
      skip_m2 = (c == 0) ? skip : 1'($urandom_range(0, 1));
      abort   = (c == ab_idx);
      ld_address    = 18'($urandom); ld_write_data = 16'($urandom);
      ld_we_n       = 1'($urandom_range(0, 1));
      m2_address    = 18'($urandom); m2_write_data = 16'($urandom);
      m2_we_n       = 1'($urandom_range(0, 1));
      if (force_m1) begin
        m1_address = 18'd146944; m1_write_data = 16'hABCD; m1_we_n = 1'b0;
      end else begin
        m1_address    = 18'($urandom); m1_write_data = 16'($urandom);
        m1_we_n       = 1'($urandom_range(0, 1));
      end
      #1;
      chk($sformatf("status c=%0d", c),
          {stage, busy, ld_enable, m2_enable, m1_enable, seq_done, error}, e);
      case (st)
        1: begin ea = ld_address; ed = ld_write_data; ew = ld_we_n; end
        2: begin ea = m2_address; ed = m2_write_data; ew = m2_we_n; end
        3: begin ea = m1_address; ed = m1_write_data; ew = m1_we_n; end
        default: begin ea = 18'd0; ed = 16'd0; ew = 1'b1; end
      endcase
      chk($sformatf("sram c=%0d", c), {SRAM_address, SRAM_write_data, SRAM_we_n},
          {ea, ed, ew});
      if (ev < 0 && (seq_done || error)) begin
        ev = c - 1;
        ev_err = error;
      end
      if (acc_q[c] >= 0) model_last = acc_q[c];
    end
    {ld_done, m2_done, m1_done} = 3'b000;
    start = 1'b0; abort = 1'b0;
    chk("last_cycles", last_cycles, model_last);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int ev;
    bit ev_err;

    tbl[0] = '{0, 20,  50,  30, 111,  30, 0};
    tbl[1] = '{1,  5,   0,   7,  18,   7, 0};
    tbl[2] = '{0,  1,   1,   1,  14,   1, 0};
    tbl[3] = '{0,  3,   4, 100, 118, 100, 0};   // done on the timeout cycle wins
    tbl[4] = '{0,  3,   4,   0, 118,   4, 1};   // M1 timeout
    tbl[5] = '{1,  2,   0,   0, 108,   2, 1};   // M1 timeout after skip
    tbl[6] = '{0,  1, 100,   2, 114,   2, 0};
    tbl[7] = '{1, 150,  0,   5, 161,   5, 0};   // long load, no timeout

    start = 0; skip_m2 = 0; abort = 0;
    ld_done = 0; m2_done = 0; m1_done = 0;
    ld_address = 18'h3FFFF; m2_address = 18'h12345; m1_address = 18'h00FFF;
    ld_write_data = 16'h1111; m2_write_data = 16'h2222; m1_write_data = 16'h3333;
    ld_we_n = 0; m2_we_n = 0; m1_we_n = 0;

    // Reset state
    Resetn = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset status", {stage, busy, ld_enable, m2_enable, m1_enable, seq_done, error}, 9'd0);
    chk("reset sram", {SRAM_address, SRAM_write_data, SRAM_we_n}, {18'd0, 16'd0, 1'b1});
    chk("reset last_cycles", last_cycles, 0);
    Resetn = 1'b1;

    // Table-driven full sequences
    for (int i = 0; i < 8; i++) begin
      force_m1 = (i == 0);
      run(tbl[i].skip, tbl[i].d_ld, tbl[i].d_m2, tbl[i].d_m1, -1, ev, ev_err);
      chk($sformatf("tbl%0d event cycle", i), ev, tbl[i].exp_ev);
      chk($sformatf("tbl%0d error flag", i), ev_err, tbl[i].exp_err);
      chk($sformatf("tbl%0d last_cycles", i), last_cycles, tbl[i].exp_last);
    end
    force_m1 = 1'b0;

    // Abort in M2_RUN on the same cycle as m2_done (index 14 = M2 counter 5)
    run(0, 3, 5, 5, 14, ev, ev_err);
    chk("abort_m2 no event", ev, -1);
    chk("abort_m2 last_cycles kept", last_cycles, 3);
    run(0, 2, 3, 4, -1, ev, ev_err);
    chk("restart event cycle", ev, 3 + 4 + 4 + 4 + 5);
    chk("restart last_cycles", last_cycles, 4);

    // abort together with start in IDLE
    run(0, 5, 5, 5, 0, ev, ev_err);
    chk("abort_start no event", ev, -1);

    // Reset mid-LD_RUN
    @(posedge Clock); #1;
    start = 1'b1; skip_m2 = 1'b0;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    chk("pre_reset stage", stage, 1);
    #2 Resetn = 1'b0;
    #1;
    chk("async reset status",
        {stage, busy, ld_enable, m2_enable, m1_enable, seq_done, error}, 9'd0);
    chk("async reset sram", {SRAM_address, SRAM_write_data, SRAM_we_n},
        {18'd0, 16'd0, 1'b1});
    chk("async reset last_cycles", last_cycles, 0);
    model_last = 0;
    @(posedge Clock); #1;
    Resetn = 1'b1;
    run(1, 4, 0, 6, -1, ev, ev_err);
    chk("post_reset event cycle", ev, 5 + 4 + 7);

    // Randomized scenarios, some aborted at a random cycle
    for (int n = 0; n < 8; n++) begin
      bit s;
      int a, b, m, r, ab;
      s = 1'($urandom_range(0, 1));
      a = $urandom_range(1, 40);
      r = $urandom_range(0, 9);
      b = (r == 0) ? 0 : (r == 1) ? TMO : $urandom_range(1, 60);
      r = $urandom_range(0, 9);
      m = (r == 0) ? 0 : (r == 1) ? TMO : $urandom_range(1, 60);
      build(s, a, b, m, -1);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, exp_q.size() - 3) : -1;
      run(s, a, b, m, ab, ev, ev_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
